// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the core's memory arbitration
package cpu_pkg;
  typedef enum logic {OWN_IF, OWN_DM} t_mem_owner;
  typedef struct packed {
    logic [31:0] adrs;
    logic        wr_en;
    logic [3:0]  byt_en;
    logic        sign_ext;
    logic [31:0] wr_data;
  } t_mem_req;
  localparam logic [3:0] MEM_FETCH_BYT_EN = 4'b1111;
endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe: fixed-latency {valid, owner} tags that route read data back to its requester
module mem_arb_tag_pipe
  import cpu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  t_mem_owner in_owner_i,
  output logic       out_valid_o,
  output t_mem_owner out_owner_o
);
  logic [RD_LATENCY-1:0] valid_q, own_q;
  logic [RD_LATENCY:0]   valid_d, own_d;
  assign valid_d = {valid_q, in_valid_i};
  assign own_d   = {own_q, in_owner_i};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      own_q   <= '0;
    end else begin
      valid_q <= valid_d[RD_LATENCY-1:0];
      own_q   <= own_d[RD_LATENCY-1:0];
    end
  end
  assign out_valid_o = valid_q[RD_LATENCY-1];
  assign out_owner_o = t_mem_owner'(own_q[RD_LATENCY-1]);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters
// with data priority, stall lock, and a starvation guard for fetch.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_adrs,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic [31:0] dm_adrs,
  input  logic        dm_wr_en,
  input  logic [3:0]  dm_byt_en,
  input  logic        dm_sign_ext,
  input  logic [31:0] dm_wr_data,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_adrs,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byt_en,
  output logic        mem_sign_ext,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic       lock_valid_q, lock_valid_d;
  t_mem_owner lock_owner_q, lock_owner_d, winner, rsp_owner;
  logic [3:0] starve_q, starve_d;
  t_mem_req   if_req, dm_req, mem_req;
  logic       accept, if_acc, dm_acc, rsp_valid;
  always_comb begin
    if_req        = '{adrs: if_adrs, wr_en: 1'b0, byt_en: MEM_FETCH_BYT_EN, sign_ext: 1'b0, wr_data: 32'h0};
    dm_req        = '{adrs: dm_adrs, wr_en: dm_wr_en, byt_en: dm_byt_en, sign_ext: dm_sign_ext, wr_data: dm_wr_data};
    winner        = lock_valid_q ? lock_owner_q :
                    (if_req_valid && (!dm_req_valid || starve_q == LIMIT)) ? OWN_IF : OWN_DM;
    mem_req_valid = !rst && (winner == OWN_IF ? if_req_valid : dm_req_valid);
    mem_req       = !mem_req_valid ? '0 : (winner == OWN_IF ? if_req : dm_req);
    accept        = mem_req_valid && mem_ready;
    if_acc        = accept && winner == OWN_IF;
    dm_acc        = accept && winner == OWN_DM;
    // A presented but unaccepted request pins the owner so the memory sees a stable request.
    lock_valid_d  = mem_req_valid && !mem_ready;
    lock_owner_d  = winner;
    starve_d      = (!if_req_valid || if_acc) ? 4'd0 :
                    (dm_acc && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_IF;
      starve_q     <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
    end
  end
  assign if_req_ready = if_acc;
  assign dm_req_ready = dm_acc;
  assign mem_adrs     = mem_req.adrs;
  assign mem_wr_en    = mem_req.wr_en;
  assign mem_byt_en   = mem_req.byt_en;
  assign mem_sign_ext = mem_req.sign_ext;
  assign mem_wr_data  = mem_req.wr_data;
  mem_arb_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept && !mem_req.wr_en),
    .in_owner_i  (winner),
    .out_valid_o (rsp_valid),
    .out_owner_o (rsp_owner)
  );
  assign if_rsp_valid = rsp_valid && rsp_owner == OWN_IF;
  assign dm_rsp_valid = rsp_valid && rsp_owner == OWN_DM;
  assign if_rsp_data  = mem_rd_data;
  assign dm_rsp_data  = mem_rd_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks drive requests and queue expected read responses;
// a negedge monitor pops the queue and checks every response routed back.
module tb_mem_arbiter;
  import cpu_pkg::*;
  localparam int LAT = 2;
  localparam int SL  = 3;
  logic        clk = 1'b0, rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_adrs, if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_wr_en, dm_sign_ext, dm_rsp_valid;
  logic [31:0] dm_adrs, dm_wr_data, dm_rsp_data;
  logic [3:0]  dm_byt_en;
  logic        mem_req_valid, mem_ready, mem_wr_en, mem_sign_ext;
  logic [31:0] mem_adrs, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_byt_en;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic is_if; logic [31:0] data; int due;} exp_t;
  exp_t sb[$];
  logic [31:0] dpipe [LAT];

  mem_arbiter #(.RD_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_adrs(if_adrs),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_adrs(dm_adrs),
    .dm_wr_en(dm_wr_en), .dm_byt_en(dm_byt_en), .dm_sign_ext(dm_sign_ext),
    .dm_wr_data(dm_wr_data), .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_ready(mem_ready), .mem_adrs(mem_adrs),
    .mem_wr_en(mem_wr_en), .mem_byt_en(mem_byt_en), .mem_sign_ext(mem_sign_ext),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h100 ? 32'h0050_0093 : a ^ 32'hC0DE_0000;
  endfunction

  // Memory stub: returns mem_f(address) LAT cycles after an accepted read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dpipe[0] <= (mem_req_valid && mem_ready && !mem_wr_en) ? mem_f(mem_adrs) : 32'h0;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_rd_data = dpipe[LAT-1];

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checks++;
      if (if_rsp_valid !== sb[0].is_if || dm_rsp_valid !== !sb[0].is_if ||
          (sb[0].is_if ? if_rsp_data : dm_rsp_data) !== sb[0].data) begin
        failures++;
        $display("FAIL rsp cyc=%0d: got if_v=%b dm_v=%b if_d=%h dm_d=%h, want is_if=%b data=%h",
                 cyc, if_rsp_valid, dm_rsp_valid, if_rsp_data, dm_rsp_data, sb[0].is_if, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rsp cyc=%0d: got if_v=%b dm_v=%b, want none", cyc, if_rsp_valid, dm_rsp_valid);
    end
  end

  task automatic idle();
    if_req_valid = 0; dm_req_valid = 0; dm_wr_en = 0; dm_byt_en = 4'hF;
    dm_sign_ext = 0; dm_wr_data = 0; mem_ready = 1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic is_if, input logic [31:0] a);
    sb.push_back('{is_if, mem_f(a), cyc + LAT});
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 2) next();
  endtask

  task automatic test_reset();
    rst = 1; idle(); if_req_valid = 1; dm_req_valid = 1; if_adrs = 32'h10; dm_adrs = 32'h44;
    #1;
    checks++;
    if ({mem_req_valid, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b want 00000", {mem_req_valid, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid});
    end
    checks++;
    if ({mem_adrs, mem_wr_en, mem_byt_en, mem_sign_ext, mem_wr_data} !== 70'b0) begin
      failures++;
      $display("FAIL reset_fields: got adrs=%h byt=%b want 0", mem_adrs, mem_byt_en);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0; idle();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, if_req_ready, dm_req_ready} !== 3'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 000", {mem_req_valid, if_req_ready, dm_req_ready});
    end
    next();
  endtask

  task automatic test_fetch_only();
    if_req_valid = 1; if_adrs = 32'h100;
    @(negedge clk);
    checks++;
    if ({if_req_ready, dm_req_ready, mem_req_valid} !== 3'b101) begin
      failures++;
      $display("FAIL fetch_ready: got %b want 101", {if_req_ready, dm_req_ready, mem_req_valid});
    end
    checks++;
    if ({mem_adrs, mem_wr_en, mem_byt_en, mem_sign_ext, mem_wr_data} !== {32'h100, 1'b0, 4'hF, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL fetch_fields: got adrs=%h we=%b byt=%b se=%b wd=%h want 100/0/1111/0/0",
               mem_adrs, mem_wr_en, mem_byt_en, mem_sign_ext, mem_wr_data);
    end
    push(1'b1, 32'h100);
    next();
    drain();
  endtask

  task automatic test_conflict();
    logic [7:0]  pat = 8'b1000_1000;
    logic [31:0] exp_a;
    int ni = 0, nd = 0;
    for (int i = 0; i < 8; i++) begin
      if_req_valid = 1; if_adrs = 32'h1000 + 32'(4 * ni);
      dm_req_valid = 1; dm_adrs = 32'h2000 + 32'(4 * nd); dm_wr_en = 0;
      exp_a = pat[i] ? if_adrs : dm_adrs;
      @(negedge clk);
      checks++;
      if ({if_req_ready, dm_req_ready} !== {pat[i], !pat[i]}) begin
        failures++;
        $display("FAIL conflict_grant[%0d]: got if/dm=%b%b want %b%b", i, if_req_ready, dm_req_ready, pat[i], !pat[i]);
      end
      checks++;
      if (mem_adrs !== exp_a) begin
        failures++;
        $display("FAIL conflict_adrs[%0d]: got %h want %h", i, mem_adrs, exp_a);
      end
      push(pat[i], exp_a);
      if (pat[i]) ni++; else nd++;
      next();
    end
    drain();
  endtask

  task automatic test_stall_lock();
    mem_ready = 0; dm_req_valid = 1; dm_adrs = 32'h200; dm_wr_en = 1; dm_wr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin if_req_valid = 1; if_adrs = 32'h300; end
      @(negedge clk);
      checks++;
      if ({mem_req_valid, if_req_ready, dm_req_ready, mem_adrs, mem_wr_en, mem_wr_data} !==
          {3'b100, 32'h200, 1'b1, 32'hDEAD_BEEF}) begin
        failures++;
        $display("FAIL stall_store[%0d]: got v=%b rdy=%b%b adrs=%h we=%b wd=%h want 1/00/200/1/deadbeef",
                 i, mem_req_valid, if_req_ready, dm_req_ready, mem_adrs, mem_wr_en, mem_wr_data);
      end
      next();
    end
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_accept_dm: got %b want 01", {if_req_ready, dm_req_ready});
    end
    next();
    dm_req_valid = 0; dm_wr_en = 0;
    @(negedge clk);
    checks++;
    if ({if_req_ready, mem_adrs} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL stall_then_if: got rdy=%b adrs=%h want 1/300", if_req_ready, mem_adrs);
    end
    push(1'b1, 32'h300);
    next();
    // Fetch stalled first: a later data request must not steal the locked grant.
    if_req_valid = 1; if_adrs = 32'h400; mem_ready = 0;
    next();
    dm_req_valid = 1; dm_adrs = 32'h480;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, if_req_ready, dm_req_ready, mem_adrs} !== {3'b100, 32'h400}) begin
      failures++;
      $display("FAIL lock_if_hold: got v=%b rdy=%b%b adrs=%h want 1/00/400", mem_req_valid, if_req_ready, dm_req_ready, mem_adrs);
    end
    next();
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL lock_if_accept: got %b want 10", {if_req_ready, dm_req_ready});
    end
    push(1'b1, 32'h400);
    next();
    drain();
  endtask

  task automatic test_mixed();
    if_req_valid = 1; if_adrs = 32'h0;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin failures++; $display("FAIL mixed_if0: got %b want 1", if_req_ready); end
    push(1'b1, 32'h0);
    next();
    if_req_valid = 0; dm_req_valid = 1; dm_adrs = 32'h40;
    @(negedge clk);
    checks++;
    if (dm_req_ready !== 1'b1) begin failures++; $display("FAIL mixed_dm40: got %b want 1", dm_req_ready); end
    push(1'b0, 32'h40);
    next();
    dm_req_valid = 0; if_req_valid = 1; if_adrs = 32'h4;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin failures++; $display("FAIL mixed_if4: got %b want 1", if_req_ready); end
    push(1'b1, 32'h4);
    next();
    drain();
  endtask

  task automatic test_subword();
    dm_req_valid = 1; dm_adrs = 32'h81; dm_byt_en = 4'b0001; dm_sign_ext = 1;
    @(negedge clk);
    checks++;
    if ({dm_req_ready, mem_byt_en, mem_sign_ext} !== {1'b1, 4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL subword_dm: got rdy=%b byt=%b se=%b want 1/0001/1", dm_req_ready, mem_byt_en, mem_sign_ext);
    end
    push(1'b0, 32'h81);
    next();
    dm_req_valid = 0; dm_wr_data = 32'h1234_5678; if_req_valid = 1; if_adrs = 32'h500;
    @(negedge clk);
    checks++;
    if ({if_req_ready, mem_byt_en, mem_sign_ext, mem_wr_en, mem_wr_data} !== {1'b1, 4'hF, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL subword_then_if: got rdy=%b byt=%b se=%b we=%b wd=%h want 1/1111/0/0/0",
               if_req_ready, mem_byt_en, mem_sign_ext, mem_wr_en, mem_wr_data);
    end
    push(1'b1, 32'h500);
    next();
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      if_req_valid = 1; if_adrs = 32'h600; dm_req_valid = 1; dm_adrs = 32'h700 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (dm_req_ready !== 1'b1) begin failures++; $display("FAIL midflight_dm[%0d]: got %b want 1", i, dm_req_ready); end
      push(1'b0, dm_adrs);
      next();
    end
    #1 rst = 1;
    sb.delete();
    #1;
    checks++;
    if ({mem_req_valid, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, mem_adrs} !== 37'b0) begin
      failures++;
      $display("FAIL midflight_async: got v=%b rdy=%b%b rsp=%b%b adrs=%h want all 0",
               mem_req_valid, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, mem_adrs);
    end
    next();
    next();
    rst = 0; dm_adrs = 32'h7F0;
    @(negedge clk);
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midflight_starve_cleared: got %b want 01", {if_req_ready, dm_req_ready});
    end
    push(1'b0, 32'h7F0);
    next();
    drain();
  endtask

  initial begin
    rst = 1; idle(); if_adrs = 0; dm_adrs = 0;
    test_reset();
    test_fetch_only();
    test_conflict();
    test_stall_lock();
    test_mixed();
    test_subword();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one unified synchronous memory port between the instruction-fetch requester and the data-access requester of the core. Each requester and the memory use a valid/ready request handshake. Read responses return a fixed latency later and are routed back to the requester that owns them. Data accesses have priority, and a starvation counter guarantees fetch progress.

Parameters:
RD_LATENCY, 1, cycles from accepted read request to mem_rd_data valid (1..4)
STARVE_LIMIT, 3, consecutive lost arbitrations after which fetch wins a conflict (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req_valid  in  1  fetch request (always a read)
if_req_ready  out  1  fetch request accepted this cycle
if_adrs  in  32  fetch address
if_rsp_valid  out  1  fetch read data valid
if_rsp_data  out  32  fetch read data (mirrors mem_rd_data)
dm_req_valid  in  1  data request
dm_req_ready  out  1  data request accepted this cycle
dm_adrs  in  32  data address
dm_wr_en  in  1  1=store, 0=load
dm_byt_en  in  4  byte enables
dm_sign_ext  in  1  sign-extend sub-word load
dm_wr_data  in  32  store data
dm_rsp_valid  out  1  load data valid
dm_rsp_data  out  32  load data (mirrors mem_rd_data)
mem_req_valid  out  1  request to memory
mem_ready  in  1  memory accepts request this cycle
mem_adrs  out  32  memory address
mem_wr_en  out  1  memory write enable
mem_byt_en  out  4  memory byte enables (4'b1111 for fetch)
mem_sign_ext  out  1  memory sign extension (0 for fetch)
mem_wr_data  out  32  memory write data (0 for fetch)
mem_rd_data  in  32  memory read data, RD_LATENCY cycles after accepted read

Behaviour:
- Reset (async, rst=1): lock cleared, starve_cnt=0, tag pipe cleared. All valid/ready outputs are 0, mem_* request fields are 0, rsp_data follows mem_rd_data.
- Requesters hold valid and their payload stable until ready. Ready is combinational: granted & mem_ready.
- Grant selection when unlocked:
  - Only one valid: that requester wins.
  - Both valid: dm wins, unless starve_cnt==STARVE_LIMIT, in which case if wins.
- Lock: if a grant is presented (mem_req_valid=1) and mem_ready=0, lock_valid=1 and lock_owner=winner are registered. The same owner stays granted until accepted, so the memory request never changes while stalled. The lock clears on acceptance.
- Acceptance = mem_req_valid & mem_ready. This completes exactly one transfer, and the grant can change on the next cycle.
- mem_* fields are muxed from the owner. Fetch drives wr_en=0, byt_en=4'b1111, sign_ext=0, wr_data=0.
- starve_cnt rules:
  - Increments, saturating at STARVE_LIMIT, on each cycle where if_req_valid=1, dm is accepted and if is not.
  - Clears when if is accepted or if_req_valid=0.
  - Holds while mem_ready=0.
- Tag pipe: shift register of RD_LATENCY entries {valid, owner}, advancing every cycle (not stalled by mem_ready).
  - Entry 0 loads {1, owner} on an accepted read and {0, x} otherwise. Accepted stores load valid=0.
  - The last stage drives if_rsp_valid or dm_rsp_valid, one-hot, for exactly one cycle.
  - Responses have no backpressure; requesters must sink them.
- Back-to-back: one accepted request per cycle. Up to RD_LATENCY reads are in flight, and responses return in order.
- Simultaneous events: a response and a new acceptance in the same cycle are independent.
- Reset mid-operation discards in-flight tags: no response is issued for reads accepted before reset.

Decomposition:
- cpu_pkg gains:
  - t_mem_owner enum {OWN_IF, OWN_DM}
  - t_mem_req struct {adrs, wr_en, byt_en, sign_ext, wr_data}
  - constant MEM_FETCH_BYT_EN=4'b1111
- One sub-module, mem_arb_tag_pipe (RD_LATENCY-deep {valid, owner} shift register with async reset). The arbitration, lock and starvation logic stay in mem_arbiter.

Test Plan:
- Fetch only: if_req_valid=1, if_adrs=0x100, mem_ready=1, mem_rd_data=0x00500093 one cycle later -> if_req_ready=1 in cycle 0; if_rsp_valid=1 with if_rsp_data=0x00500093 in cycle 1; dm_rsp_valid stays 0.
- Conflict: both valid every cycle, mem_ready=1, STARVE_LIMIT=3 -> acceptances go dm,dm,dm,if,dm,dm,dm,if. starve_cnt sequence is 1,2,3,0 per block of four.
- Stall lock: dm store 0x200/0xDEADBEEF presented, mem_ready=0 for 3 cycles while if_req_valid rises -> mem_* stays the store for all 3 cycles. dm accepted when mem_ready=1, then if is granted; no if_rsp for the store.
- Mixed in-flight, RD_LATENCY=2: accepted reads if@0x0, dm@0x40, if@0x4 on consecutive cycles -> responses if, dm, if on cycles 2, 3, 4, with data matching.
- Reset mid-flight: dm load accepted, rst asserted asynchronously before latency expires -> all outputs 0 immediately; no dm_rsp_valid after rst deasserts; starve_cnt=0.
- Sub-word load: dm load byt_en=4'b0001, sign_ext=1 -> mem_byt_en=4'b0001 and mem_sign_ext=1 on the acceptance cycle; a fetch granted next shows mem_byt_en=4'b1111, mem_sign_ext=0.
